// File: rtl/clock_meas_pkg.sv
//------------------------------------------------------------------------------
// clock_meas_pkg : shared widths, state encoding and timeout default for the
//                  clock divider / clock period meter pair.
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package clock_meas_pkg;

    localparam int DEF_WIDTH = 36;

    // Largest count a DEF_WIDTH counter can reach without wrapping.
    localparam logic [DEF_WIDTH-1:0] DEF_TIMEOUT = '1;

    typedef enum logic {
        WAIT_FIRST = 1'b0,
        MEASURE    = 1'b1
    } meas_state_t;

endpackage

`default_nettype wire

// File: rtl/sync_edge_detect.sv
//------------------------------------------------------------------------------
// sync_edge_detect : SYNC_STAGES-flop synchronizer plus one delay flop,
//                    giving the synchronized level and a rising-edge strobe.
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock_in,
    input  logic reset_n,
    input  logic i_sig,
    output logic o_s,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_s_d;

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
            r_s_d  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
            r_s_d  <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_s    = r_sync[SYNC_STAGES-1];
    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_s_d;

endmodule

`default_nettype wire

// File: rtl/clock_period_meter.sv
//------------------------------------------------------------------------------
// clock_period_meter : measures period and high time of an asynchronous
//                      clock-like input in clock_in cycles.
// Optional macro CLOCK_PERIOD_METER_DUTY_EN enables high-time measurement;
// without it high_out is tied to 0.
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module clock_period_meter
    import clock_meas_pkg::*;
#(
    parameter int               WIDTH       = DEF_WIDTH,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] TIMEOUT     = WIDTH'(DEF_TIMEOUT)
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period_out,
    output logic [WIDTH-1:0] high_out,
    output logic             valid,
    output logic             timeout
);

    logic w_s;
    logic w_rise;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clock_in (clock_in),
        .reset_n  (reset_n),
        .i_sig    (sig_in),
        .o_s      (w_s),
        .o_rise   (w_rise)
    );

    meas_state_t      r_state,   w_state_nxt;
    logic [WIDTH-1:0] r_per_cnt, w_per_cnt_nxt;
    logic [WIDTH-1:0] r_period,  w_period_nxt;
    logic             r_valid,   w_valid_nxt;
    logic             r_timeout, w_timeout_nxt;
    logic             w_capture;
    logic [WIDTH-1:0] w_high;

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= WAIT_FIRST;
            r_per_cnt <= '0;
            r_period  <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_per_cnt <= w_per_cnt_nxt;
            r_period  <= w_period_nxt;
            r_valid   <= w_valid_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    // A rise on the cycle the count hits TIMEOUT still yields a measurement.
    always_comb begin
        w_state_nxt   = r_state;
        w_per_cnt_nxt = r_per_cnt;
        w_period_nxt  = r_period;
        w_valid_nxt   = 1'b0;
        w_timeout_nxt = r_timeout;
        w_capture     = 1'b0;
        case (r_state)
            WAIT_FIRST: begin
                if (w_rise) begin
                    w_per_cnt_nxt = {{(WIDTH-1){1'b0}}, 1'b1};
                    w_state_nxt   = MEASURE;
                end
            end
            MEASURE: begin
                if (w_rise) begin
                    w_capture     = 1'b1;
                    w_period_nxt  = r_per_cnt;
                    w_valid_nxt   = 1'b1;
                    w_timeout_nxt = 1'b0;
                    w_per_cnt_nxt = {{(WIDTH-1){1'b0}}, 1'b1};
                end else if (r_per_cnt == TIMEOUT) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = WAIT_FIRST;
                end else begin
                    w_per_cnt_nxt = r_per_cnt + 1'b1;
                end
            end
            default: w_state_nxt = WAIT_FIRST;
        endcase
    end

`ifdef CLOCK_PERIOD_METER_DUTY_EN
    logic [WIDTH-1:0] r_hi_cnt;
    logic [WIDTH-1:0] r_high;

    // hi_cnt never exceeds per_cnt, so the TIMEOUT guard keeps it from wrapping.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_hi_cnt <= '0;
            r_high   <= '0;
        end else begin
            if (w_capture) begin
                r_high <= r_hi_cnt;
            end
            if (w_rise) begin
                r_hi_cnt <= {{(WIDTH-1){1'b0}}, 1'b1};
            end else if (r_state == MEASURE && w_s && r_per_cnt != TIMEOUT) begin
                r_hi_cnt <= r_hi_cnt + 1'b1;
            end
        end
    end

    assign w_high = r_high;
`else
    logic w_unused_duty;
    assign w_unused_duty = w_s & w_capture;
    assign w_high        = '0;
`endif

    assign period_out = r_period;
    assign high_out   = w_high;
    assign valid      = r_valid;
    assign timeout    = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_clock_period_meter.sv
//------------------------------------------------------------------------------
// tb_clock_period_meter : self-checking bench comparing the meter against a
//                         gap-based reference model of the input waveform.
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_clock_period_meter;

    localparam int WIDTH = 36;
    localparam int SYNC  = 2;
    localparam int TMO   = 20;

    logic             clk     = 1'b0;
    logic             reset_n = 1'b0;
    logic             sig_in  = 1'b0;
    logic [WIDTH-1:0] period_out;
    logic [WIDTH-1:0] high_out;
    logic             valid;
    logic             timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    clock_period_meter #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC),
        .TIMEOUT     (36'd20)
    ) dut (
        .clock_in   (clk),
        .reset_n    (reset_n),
        .sig_in     (sig_in),
        .period_out (period_out),
        .high_out   (high_out),
        .valid      (valid),
        .timeout    (timeout)
    );

    // Input waveform, one entry per clock_in cycle.
    bit wave[$];

    // Reference model: tracks the last rise index and derives results from gaps.
    bit     m_armed;
    int     m_last;
    bit     m_valid;
    bit     m_timeout;
    longint m_per;
    longint m_hi;

    task automatic model_reset();
        m_armed   = 1'b0;
        m_last    = 0;
        m_valid   = 1'b0;
        m_timeout = 1'b0;
        m_per     = 0;
        m_hi      = 0;
    endtask

    task automatic model_step(input int u);
        bit cur;
        bit prev;
        cur     = wave[u];
        prev    = (u == 0) ? 1'b0 : wave[u-1];
        m_valid = 1'b0;
        if (cur && !prev) begin
            if (m_armed) begin
                m_valid   = 1'b1;
                m_per     = u - m_last;
                m_hi      = 0;
                for (int j = m_last; j < u; j++) m_hi += wave[j];
                m_timeout = 1'b0;
            end
            m_armed = 1'b1;
            m_last  = u;
        end else if (m_armed && (u - m_last) == TMO) begin
            m_timeout = 1'b1;
            m_armed   = 1'b0;
        end
    endtask

    task automatic add_periods(input int p, input int h, input int n);
        for (int k = 0; k < n; k++)
            for (int c = 0; c < p; c++) wave.push_back(c < h);
    endtask

    task automatic add_level(input bit lvl, input int n);
        for (int c = 0; c < n; c++) wave.push_back(lvl);
    endtask

    // Asserts reset between clock edges and checks that outputs clear at once.
    task automatic apply_reset(input string name);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (period_out !== '0 || high_out !== '0 || valid !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL %s_reset: got period=%0d high=%0d valid=%0b timeout=%0b, expected all 0",
                     name, period_out, high_out, valid, timeout);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic run_wave(input string name);
        longint exp_hi;
        apply_reset(name);
        model_reset();
        for (int t = 0; t < wave.size(); t++) begin
            sig_in = wave[t];
            @(posedge clk);
            #1;
            if (t - SYNC >= 0) model_step(t - SYNC);
`ifdef CLOCK_PERIOD_METER_DUTY_EN
            exp_hi = m_hi;
`else
            exp_hi = 0;
`endif
            checks++;
            if (valid !== m_valid || timeout !== m_timeout ||
                period_out !== WIDTH'(m_per) || high_out !== WIDTH'(exp_hi)) begin
                errors++;
                $display("FAIL %s cycle %0d: got valid=%0b timeout=%0b period=%0d high=%0d, expected valid=%0b timeout=%0b period=%0d high=%0d",
                         name, t, valid, timeout, period_out, high_out,
                         m_valid, m_timeout, m_per, exp_hi);
            end
        end
        wave.delete();
    endtask

    task automatic test_reset();
        add_level(1'b0, 4);
        run_wave("reset");
    endtask

    task automatic test_divide(input int d);
        add_level(1'b0, 2);
        add_periods(d, d / 2 + ((d % 2 != 0) ? 1 : 0) - ((d == 7) ? 1 : 0), 8);
        run_wave($sformatf("divide%0d", d));
    endtask

    task automatic test_timeout_low();
        add_level(1'b0, 2);
        add_periods(5, 2, 3);
        wave.push_back(1'b1);
        add_level(1'b0, 30);
        add_periods(5, 2, 4);
        run_wave("timeout_low");
    endtask

    task automatic test_timeout_high();
        add_level(1'b0, 3);
        add_periods(6, 3, 2);
        add_level(1'b1, 28);
        add_level(1'b0, 2);
        add_periods(4, 1, 4);
        run_wave("timeout_high");
    endtask

    task automatic test_boundary();
        add_level(1'b0, 2);
        add_periods(TMO, 7, 3);
        add_periods(TMO + 1, 5, 2);
        add_periods(TMO - 1, 9, 2);
        add_periods(2, 1, 5);
        add_periods(TMO, 1, 2);
        run_wave("boundary");
    endtask

    task automatic test_random();
        int p;
        add_level(1'b0, 2);
        for (int k = 0; k < 60; k++) begin
            p = $urandom_range(2, TMO + 4);
            add_periods(p, $urandom_range(1, p - 1), 1);
        end
        add_periods(3, 1, 2);
        run_wave("random");
    endtask

    task automatic test_back_to_back();
        add_level(1'b0, 1);
        add_periods(9, 4, 5);
        run_wave("mid_a");
        add_periods(3, 1, 6);
        run_wave("mid_b");
    endtask

    initial begin
        test_reset();
        test_divide(4);
        test_divide(7);
        test_divide(6);
        test_timeout_low();
        test_timeout_high();
        test_boundary();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
